// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: command scheduler and state holder for the stopwatch datapath.
// Latches button requests and a prescaled 1 s tick, arbitrates them into one-hot do_* pulses
// (reset > start > stop > tick), and commits the datapath results one cycle after each issue.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   btn_start/stop/reset   1-cycle request pulses
//   btn_toggle             start when stopped, stop when running
//   sw_do_*                one-hot datapath command pulses
//   sw_in_seconds/running  committed state handed to the datapath
//   sw_out_seconds/running datapath results, captured at the end of CAPTURE
//   seconds, running       committed state
//   busy                   a command is in flight
//   at_max                 seconds has reached MAX_SECONDS
//   tick_overrun           saturating count of dropped ticks
module stopwatch_ctrl #(
  parameter int unsigned CLK_DIV     = 50_000_000,
  parameter int unsigned MAX_SECONDS = 359_999,
  parameter int unsigned OVR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              btn_reset,
  input  logic              btn_toggle,
  output logic              sw_do_tick,
  output logic              sw_do_reset,
  output logic              sw_do_start,
  output logic              sw_do_stop,
  output logic [31:0]       sw_in_seconds,
  output logic              sw_in_running,
  input  logic [31:0]       sw_out_seconds,
  input  logic              sw_out_running,
  output logic [31:0]       seconds,
  output logic              running,
  output logic              busy,
  output logic              at_max,
  output logic [OVR_W-1:0]  tick_overrun
);

  localparam int unsigned PreW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;
  typedef enum logic [1:0] {CmdReset, CmdStart, CmdStop, CmdTick} cmd_e;

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic              p_reset_q, p_reset_d;
  logic              p_start_q, p_start_d;
  logic              p_stop_q, p_stop_d;
  logic              p_tick_q, p_tick_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [31:0]       seconds_q, seconds_d;
  logic              running_q, running_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              wrap, issue_reset, issue_tick;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    p_reset_d   = p_reset_q;
    p_start_d   = p_start_q;
    p_stop_d    = p_stop_q;
    p_tick_d    = p_tick_q;
    pre_d       = pre_q;
    seconds_d   = seconds_q;
    running_d   = running_q;
    ovr_d       = ovr_q;
    sw_do_reset = 1'b0;
    sw_do_start = 1'b0;
    sw_do_stop  = 1'b0;
    sw_do_tick  = 1'b0;
    wrap        = 1'b0;
    issue_reset = (state_q == StIssue) && (cmd_q == CmdReset);
    issue_tick  = (state_q == StIssue) && (cmd_q == CmdTick);

    // Prescaler only advances while the committed state says running.
    if (running_q) begin
      if (pre_q == PreW'(CLK_DIV - 1)) begin
        pre_d = '0;
        wrap  = 1'b1;
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (p_reset_q || p_start_q || p_stop_q || p_tick_q) begin
          state_d = StIssue;
          if (p_reset_q)      cmd_d = CmdReset;
          else if (p_start_q) cmd_d = CmdStart;
          else if (p_stop_q)  cmd_d = CmdStop;
          else                cmd_d = CmdTick;
        end
      end
      StIssue: begin
        state_d = StCapture;
        unique case (cmd_q)
          CmdReset: begin
            sw_do_reset = 1'b1;
            p_reset_d   = 1'b0;
            p_tick_d    = 1'b0;
            pre_d       = '0;
          end
          CmdStart: begin
            sw_do_start = 1'b1;
            p_start_d   = 1'b0;
          end
          CmdStop: begin
            sw_do_stop = 1'b1;
            p_stop_d   = 1'b0;
          end
          CmdTick: begin
            // A tick while stopped or saturated still consumes its slot but does nothing.
            sw_do_tick = running_q & ~at_max;
            p_tick_d   = 1'b0;
          end
        endcase
      end
      StCapture: begin
        state_d   = StIdle;
        seconds_d = (sw_out_seconds > 32'(MAX_SECONDS)) ? 32'(MAX_SECONDS) : sw_out_seconds;
        running_d = sw_out_running;
      end
      default: state_d = StIdle;
    endcase

    // A tick still pending (and not leaving this cycle) cannot hold a second one.
    if (wrap && !issue_reset) begin
      if (p_tick_q && !issue_tick) begin
        if (ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);
      end else begin
        p_tick_d = 1'b1;
      end
    end

    // New requests win over same-edge clears so nothing arriving while busy is lost.
    if (btn_reset) p_reset_d = 1'b1;
    if (btn_start) p_start_d = 1'b1;
    if (btn_stop)  p_stop_d  = 1'b1;
    if (btn_toggle && !btn_start && !btn_stop) begin
      if (running_q) p_stop_d  = 1'b1;
      else           p_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= CmdReset;
      p_reset_q <= 1'b0;
      p_start_q <= 1'b0;
      p_stop_q  <= 1'b0;
      p_tick_q  <= 1'b0;
      pre_q     <= '0;
      seconds_q <= '0;
      running_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      p_reset_q <= p_reset_d;
      p_start_q <= p_start_d;
      p_stop_q  <= p_stop_d;
      p_tick_q  <= p_tick_d;
      pre_q     <= pre_d;
      seconds_q <= seconds_d;
      running_q <= running_d;
      ovr_q     <= ovr_d;
    end
  end

  assign seconds       = seconds_q;
  assign running       = running_q;
  assign sw_in_seconds = seconds_q;
  assign sw_in_running = running_q;
  assign busy          = (state_q != StIdle);
  assign at_max        = (seconds_q == 32'(MAX_SECONDS));
  assign tick_overrun  = ovr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int unsigned Div  = 4;
  localparam int unsigned MaxS = 12;
  localparam int unsigned OvrW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            btn_start = 1'b0, btn_stop = 1'b0, btn_reset = 1'b0, btn_toggle = 1'b0;
  logic            sw_do_tick, sw_do_reset, sw_do_start, sw_do_stop;
  logic [31:0]     sw_in_seconds;
  logic            sw_in_running;
  logic [31:0]     dp_sec;
  logic            dp_run;
  logic [31:0]     seconds;
  logic            running, busy, at_max;
  logic [OvrW-1:0] tick_overrun;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_DIV(Div), .MAX_SECONDS(MaxS), .OVR_W(OvrW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start      (btn_start),
    .btn_stop       (btn_stop),
    .btn_reset      (btn_reset),
    .btn_toggle     (btn_toggle),
    .sw_do_tick     (sw_do_tick),
    .sw_do_reset    (sw_do_reset),
    .sw_do_start    (sw_do_start),
    .sw_do_stop     (sw_do_stop),
    .sw_in_seconds  (sw_in_seconds),
    .sw_in_running  (sw_in_running),
    .sw_out_seconds (dp_sec),
    .sw_out_running (dp_run),
    .seconds        (seconds),
    .running        (running),
    .busy           (busy),
    .at_max         (at_max),
    .tick_overrun   (tick_overrun)
  );

  // Registered stopwatch datapath stand-in: acts on a do_* pulse, holds its result otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sec <= '0;
      dp_run <= 1'b0;
    end else if (sw_do_reset) begin
      dp_sec <= '0;
      dp_run <= 1'b0;
    end else if (sw_do_start) begin
      dp_sec <= sw_in_seconds;
      dp_run <= 1'b1;
    end else if (sw_do_stop) begin
      dp_sec <= sw_in_seconds;
      dp_run <= 1'b0;
    end else if (sw_do_tick) begin
      dp_sec <= (sw_in_seconds < MaxS) ? sw_in_seconds + 1 : sw_in_seconds;
      dp_run <= sw_in_running;
    end
  end

  // Reference model: pending set indexed by priority (0 reset, 1 start, 2 stop, 3 tick),
  // a slot phase (0 idle, 1 issue, 2 capture) and plain integer time/second counters.
  bit [3:0] m_pend;
  int       m_phase, m_cmd, m_sec, m_res_sec, m_pre, m_ovr;
  bit       m_run, m_res_run;

  task automatic model_reset();
    m_pend = '0; m_phase = 0; m_cmd = 0; m_sec = 0; m_res_sec = 0;
    m_pre = 0; m_ovr = 0; m_run = 1'b0; m_res_run = 1'b0;
  endtask

  task automatic model_step();
    bit [3:0] pend_old;
    bit       issuing, wrap, run_old;
    pend_old = m_pend;
    issuing  = (m_phase == 1);
    run_old  = m_run;
    wrap     = 1'b0;
    if (m_run) begin
      m_pre++;
      if (m_pre == Div) begin m_pre = 0; wrap = 1'b1; end
    end
    case (m_phase)
      0: if (pend_old != 0) begin
        for (int i = 3; i >= 0; i--) if (pend_old[i]) m_cmd = i;
        m_phase = 1;
      end
      1: begin
        m_pend[m_cmd] = 1'b0;
        case (m_cmd)
          0: begin m_res_sec = 0; m_res_run = 0; m_pend[3] = 1'b0; m_pre = 0; wrap = 1'b0; end
          1: begin m_res_sec = m_sec; m_res_run = 1; end
          2: begin m_res_sec = m_sec; m_res_run = 0; end
          default: begin
            m_res_sec = (m_run && m_sec < MaxS) ? m_sec + 1 : m_sec;
            m_res_run = m_run;
          end
        endcase
        m_phase = 2;
      end
      default: begin m_sec = m_res_sec; m_run = m_res_run; m_phase = 0; end
    endcase
    if (wrap) begin
      if (pend_old[3] && !(issuing && m_cmd == 3)) m_ovr = (m_ovr == 15) ? 15 : m_ovr + 1;
      else m_pend[3] = 1'b1;
    end
    if (btn_reset) m_pend[0] = 1'b1;
    if (btn_start) m_pend[1] = 1'b1;
    if (btn_stop)  m_pend[2] = 1'b1;
    if (btn_toggle && !btn_start && !btn_stop) m_pend[run_old ? 2 : 1] = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  function automatic logic [42:0] model_vec();
    logic [3:0] d;
    d = 4'b0000;
    if (m_phase == 1) begin
      case (m_cmd)
        0: d = 4'b1000;
        1: d = 4'b0100;
        2: d = 4'b0010;
        default: d = (m_run && m_sec != MaxS) ? 4'b0001 : 4'b0000;
      endcase
    end
    return {d, m_phase != 0, m_run, m_sec == MaxS, 32'(m_sec), OvrW'(m_ovr)};
  endfunction

  function automatic logic [42:0] dut_vec();
    return {sw_do_reset, sw_do_start, sw_do_stop, sw_do_tick, busy, running, at_max,
            seconds, tick_overrun};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // btn order {reset, start, stop, toggle}
  task automatic drive(input logic [3:0] b);
    {btn_reset, btn_start, btn_stop, btn_toggle} = b;
  endtask

  task automatic async_reset();
    @(negedge clk);
    drive(4'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] do_exp;  // {reset, start, stop, tick}
    logic       busy_exp;
    logic       run_exp;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic [3:0] b, input logic [3:0] d, input logic bz,
                              input logic r);
    vec_t v;
    v.btn = b; v.do_exp = d; v.busy_exp = bz; v.run_exp = r;
    return v;
  endfunction

  initial begin
    int ticks, cyc;

    // Start -> stop -> no-op tick, start+stop together, then toggle both ways.
    tbl[0]  = mk(4'b0000, 4'b0000, 0, 0);
    tbl[1]  = mk(4'b0100, 4'b0000, 0, 0);
    tbl[2]  = mk(4'b0000, 4'b0100, 1, 0);
    tbl[3]  = mk(4'b0000, 4'b0000, 1, 0);
    tbl[4]  = mk(4'b0000, 4'b0000, 0, 1);
    tbl[5]  = mk(4'b0010, 4'b0000, 0, 1);
    tbl[6]  = mk(4'b0000, 4'b0010, 1, 1);
    tbl[7]  = mk(4'b0000, 4'b0000, 1, 1);
    tbl[8]  = mk(4'b0000, 4'b0000, 0, 0);
    tbl[9]  = mk(4'b0000, 4'b0000, 1, 0);
    tbl[10] = mk(4'b0000, 4'b0000, 1, 0);
    tbl[11] = mk(4'b0000, 4'b0000, 0, 0);
    tbl[12] = mk(4'b0110, 4'b0000, 0, 0);
    tbl[13] = mk(4'b0000, 4'b0100, 1, 0);
    tbl[14] = mk(4'b0000, 4'b0000, 1, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 0, 1);
    tbl[16] = mk(4'b0000, 4'b0010, 1, 1);
    tbl[17] = mk(4'b0000, 4'b0000, 1, 1);
    tbl[18] = mk(4'b0000, 4'b0000, 0, 0);
    tbl[19] = mk(4'b0001, 4'b0000, 0, 0);
    tbl[20] = mk(4'b0000, 4'b0100, 1, 0);
    tbl[21] = mk(4'b0000, 4'b0000, 1, 0);
    tbl[22] = mk(4'b0000, 4'b0000, 0, 1);
    tbl[23] = mk(4'b0001, 4'b0000, 0, 1);
    tbl[24] = mk(4'b0000, 4'b0010, 1, 1);
    tbl[25] = mk(4'b0000, 4'b0000, 1, 1);
    tbl[26] = mk(4'b0000, 4'b0000, 0, 0);
    tbl[27] = mk(4'b0000, 4'b0000, 1, 0);
    tbl[28] = mk(4'b0000, 4'b0000, 1, 0);
    tbl[29] = mk(4'b0000, 4'b0000, 0, 0);

    // Reset state
    @(negedge clk);
    check("reset state", dut_vec(), 43'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].btn);
      @(negedge clk);
      drive(4'b0000);
      check($sformatf("table row %0d", i),
            {sw_do_reset, sw_do_start, sw_do_stop, sw_do_tick, busy, running, seconds},
            {tbl[i].do_exp, tbl[i].busy_exp, tbl[i].run_exp, 32'd0});
    end

    // Ten ticks, then saturation at MAX_SECONDS, then a reset command.
    async_reset();
    drive(4'b0100);
    @(negedge clk);
    drive(4'b0000);
    ticks = 0; cyc = 0;
    while (ticks < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (sw_do_tick) ticks++;
    end
    check("ten tick pulses", ticks, 10);
    repeat (2) @(negedge clk);
    check("seconds after ten ticks", seconds, 10);
    check("overrun after ten ticks", tick_overrun, 0);
    check("at_max below limit", at_max, 0);
    cyc = 0;
    while (seconds != MaxS - 1 && cyc < 100) begin @(negedge clk); cyc++; end
    check("reached max-1", seconds, MaxS - 1);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sw_do_tick) ticks++;
    end
    check("only one tick past max-1", ticks, 1);
    check("seconds saturated", seconds, MaxS);
    check("at_max set", at_max, 1);
    drive(4'b1000);
    @(negedge clk);
    drive(4'b0000);
    repeat (4) @(negedge clk);
    check("reset cmd clears state", {seconds, running, at_max, busy}, 35'd0);

    // Repeated start commands keep the FSM busy while tick has lowest priority.
    async_reset();
    drive(4'b0100);
    repeat (10) @(negedge clk);
    drive(4'b0000);
    repeat (12) @(negedge clk);
    check("single dropped tick", tick_overrun, 1);
    drive(4'b0100);
    repeat (100) @(negedge clk);
    drive(4'b0000);
    repeat (4) @(negedge clk);
    check("overrun saturates", tick_overrun, 15);

    // Asynchronous reset in the middle of a start issue.
    async_reset();
    drive(4'b0100);
    @(negedge clk);
    drive(4'b0000);
    @(negedge clk);
    check("do_start before async reset", sw_do_start, 1);
    #2 rst_n = 1'b0;
    #1 check("async reset immediate", {sw_do_reset, sw_do_start, sw_do_stop, sw_do_tick,
                                       busy, running}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || running || sw_do_start) cyc++;
    end
    check("nothing survives async reset", cyc, 0);

    // Randomized traffic against the reference model.
    async_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      check($sformatf("random cycle %0d", i), dut_vec(), model_vec());
      rst_n = 1'b1;
      drive({$urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 13) == 0, $urandom_range(0, 11) == 0});
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    drive(4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
